// File: rtl/hilo_issue_ctrl_if.sv
// Bundle of E/D-stage request signals and MDU/HI-LO control outputs
// exchanged with hilo_issue_ctrl.
//   Req        : interrupt/exception request, E instruction is being flushed
//   E_md_op    : decoded md op in E (0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,
//                5 MFHI,6 MFLO,7 MTHI,8 MTLO, 9-15 NONE)
//   E_div_zero : E divisor operand is zero (meaningful with DIV/DIVU)
//   D_md_use   : D-stage instruction is an md op
//   mdu_start  : start pulse to MDU datapath
//   mdu_op     : op presented to the MDU
//   hilo_we    : load {HI,LO} from MDU result
//   hi_we/lo_we: load HI/LO from rs (MTHI/MTLO)
//   rd_sel     : E result mux select (0 none, 1 HI, 2 LO)
//   busy       : op in flight
//   stall_md   : stall the D stage
//   issue_err  : sticky flag, md op presented in E while busy
interface hilo_issue_ctrl_if;
    logic       Req;
    logic [3:0] E_md_op;
    logic       E_div_zero;
    logic       D_md_use;
    logic       mdu_start;
    logic [3:0] mdu_op;
    logic       hilo_we;
    logic       hi_we;
    logic       lo_we;
    logic [1:0] rd_sel;
    logic       busy;
    logic       stall_md;
    logic       issue_err;

    // Controller side
    modport slave (
        input  Req, E_md_op, E_div_zero, D_md_use,
        output mdu_start, mdu_op, hilo_we, hi_we, lo_we, rd_sel, busy,
               stall_md, issue_err
    );

    // Pipeline side
    modport master (
        output Req, E_md_op, E_div_zero, D_md_use,
        input  mdu_start, mdu_op, hilo_we, hi_we, lo_we, rd_sel, busy,
               stall_md, issue_err
    );
endinterface

// File: rtl/hilo_issue_ctrl.sv
// Sequencing controller for the E-stage multiply/divide unit and HI/LO.
// Issues a one-cycle start for MULT/MULTU/DIV/DIVU, counts the op latency,
// raises hilo_we on the final busy cycle, decodes MTHI/MTLO/MFHI/MFLO, and
// stalls D for any md instruction queued behind a running op.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset; forces every output to 0
//   md    : hilo_issue_ctrl_if.slave (see interface header for signals)
// Parameters:
//   MUL_CYCLES : busy cycles for MULT/MULTU (1..15)
//   DIV_CYCLES : busy cycles for DIV/DIVU (1..15)
module hilo_issue_ctrl #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic               clk,
    input  logic               reset,
    hilo_issue_ctrl_if.slave   md
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    localparam logic [3:0] MUL_N = 4'(MUL_CYCLES);
    localparam logic [3:0] DIV_N = 4'(DIV_CYCLES);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] op_q, op_d;
    logic       err_q, err_d;

    logic is_mul, is_div, is_md, idle, go, start;

    always_comb begin
        is_mul = (md.E_md_op == OP_MULT) || (md.E_md_op == OP_MULTU);
        is_div = (md.E_md_op == OP_DIV)  || (md.E_md_op == OP_DIVU);
        is_md  = (md.E_md_op != OP_NONE) && (md.E_md_op <= OP_MTLO);
        idle   = (state_q == S_IDLE);
        go     = idle && !md.Req;
        // A divide by zero never reaches the datapath; HI/LO stay untouched.
        start  = go && (is_mul || (is_div && !md.E_div_zero));
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        err_d   = err_q;
        if (start) begin
            state_d = S_RUN;
            cnt_d   = is_mul ? MUL_N : DIV_N;
            op_d    = md.E_md_op;
        end
        if (state_q == S_RUN) begin
            if (cnt_q > 4'd1) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            // The running op is committed; an md op in E now is a hazard
            // that the stall should have prevented, so flag it and drop it.
            if (is_md) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

    // Outputs. Combinational terms are gated by reset so that every output
    // reads 0 while reset is held, not just after the next edge.
    always_comb begin
        md.mdu_start = !reset && start;
        md.mdu_op    = reset ? '0 : (start ? md.E_md_op : op_q);
        md.hilo_we   = !reset && (state_q == S_RUN) && (cnt_q == 4'd1);
        md.hi_we     = !reset && go && (md.E_md_op == OP_MTHI);
        md.lo_we     = !reset && go && (md.E_md_op == OP_MTLO);
        md.rd_sel    = 2'd0;
        if (!reset && idle) begin
            if (md.E_md_op == OP_MFHI) begin
                md.rd_sel = 2'd1;
            end else if (md.E_md_op == OP_MFLO) begin
                md.rd_sel = 2'd2;
            end
        end
        md.busy      = !reset && (state_q == S_RUN);
        md.stall_md  = !reset && md.D_md_use && ((state_q == S_RUN) || start);
        md.issue_err = err_q;
    end

endmodule
